// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the time-set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } set_state_t;

  localparam logic [3:0] HR_MAX_TENS  = 4'd2;
  localparam logic [3:0] HR_MAX_UNITS = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX      = 4'd9;

  // HH:MM as four BCD digits
  typedef struct packed {
    logic [3:0] hr_tens;
    logic [3:0] hr_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
  } bcd_time_t;

  // Hours +1 with 23 -> 00 wrap; minutes untouched
  function automatic bcd_time_t inc_hours(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hr_tens == HR_MAX_TENS && t.hr_units == HR_MAX_UNITS) begin
      r.hr_tens  = 4'd0;
      r.hr_units = 4'd0;
    end else if (t.hr_units == BCD_MAX) begin
      r.hr_tens  = t.hr_tens + 4'd1;
      r.hr_units = 4'd0;
    end else begin
      r.hr_units = t.hr_units + 4'd1;
    end
    return r;
  endfunction

  // Minutes +1 with 59 -> 00 wrap; no carry into hours
  function automatic bcd_time_t inc_minutes(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_tens == MIN_MAX_TENS && t.min_units == BCD_MAX) begin
      r.min_tens  = 4'd0;
      r.min_units = 4'd0;
    end else if (t.min_units == BCD_MAX) begin
      r.min_tens  = t.min_tens + 4'd1;
      r.min_units = 4'd0;
    end else begin
      r.min_units = t.min_units + 4'd1;
    end
    return r;
  endfunction

  // Any illegal digit or out-of-range field is replaced by 00 for that field only
  function automatic bcd_time_t sanitise(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hr_units > BCD_MAX || t.hr_tens > HR_MAX_TENS ||
        (t.hr_tens == HR_MAX_TENS && t.hr_units > HR_MAX_UNITS)) begin
      r.hr_tens  = 4'd0;
      r.hr_units = 4'd0;
    end
    if (t.min_units > BCD_MAX || t.min_tens > MIN_MAX_TENS) begin
      r.min_tens  = 4'd0;
      r.min_units = 4'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle registered tick every TICK_DIV enabled cycles.
// Ports: clk, reset (async active-low), en (count enable; low holds count at 0),
//        clr (synchronous clear, overrides en), tick (registered pulse).
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  // tick is registered alongside the count reaching TICK_DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: button synchronisers and edge detect, RUN/SET_HR/SET_MIN
// FSM with BCD shadow editing, and the second-tick prescaler.
// Inputs : clk, reset (async active-low), btn_mode, btn_inc (async levels),
//          cur_hr_tens/units, cur_min_tens/units (live BCD time).
// Outputs: sec_tick, load (one-cycle strobes), set_* (shadow BCD time),
//          edit_hr, edit_min (current edit field). All registered.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hr_tens,
  input  logic [3:0] cur_hr_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  output logic       sec_tick,
  output logic       load,
  output logic [3:0] set_hr_tens,
  output logic [3:0] set_hr_units,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_units,
  output logic       edit_hr,
  output logic       edit_min
);

  logic [2:0] mode_sync, inc_sync;
  logic       mode_press, inc_press;
  set_state_t state, state_d;
  bcd_time_t  shadow, shadow_d, cur_time;
  logic       load_d;

  assign cur_time = {cur_hr_tens, cur_hr_units, cur_min_tens, cur_min_units};

  // Two sync flops, third flop for edge detect; the press pulse is registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync  <= '0;
      inc_sync   <= '0;
      mode_press <= 1'b0;
      inc_press  <= 1'b0;
    end else begin
      mode_sync  <= {mode_sync[1:0], btn_mode};
      inc_sync   <= {inc_sync[1:0], btn_inc};
      mode_press <= mode_sync[1] & ~mode_sync[2];
      inc_press  <= inc_sync[1] & ~inc_sync[2];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      shadow   <= '0;
      load     <= 1'b0;
      edit_hr  <= 1'b0;
      edit_min <= 1'b0;
    end else begin
      state    <= state_d;
      shadow   <= shadow_d;
      load     <= load_d;
      edit_hr  <= (state_d == SET_HR);
      edit_min <= (state_d == SET_MIN);
    end
  end

  // Next state; mode has priority over inc when both arrive together
  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    load_d   = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_d  = SET_HR;
          shadow_d = sanitise(cur_time);
        end
      end
      SET_HR: begin
        if (mode_press)     state_d  = SET_MIN;
        else if (inc_press) shadow_d = inc_hours(shadow);
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_press) begin
          shadow_d = inc_minutes(shadow);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign set_hr_tens   = shadow.hr_tens;
  assign set_hr_units  = shadow.hr_units;
  assign set_min_tens  = shadow.min_tens;
  assign set_min_units = shadow.min_units;

  // Enable follows the next state so tick stops on the same edge as RUN exit;
  // clearing during and after load puts the next tick TICK_DIV cycles past load
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_d == RUN),
    .clr   (load_d | load),
    .tick  (sec_tick)
  );

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV = 10.
module tb_clock_set_ctrl;

  localparam int unsigned TICK_DIV = 10;

  logic       clk;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic [3:0] cur_hr_tens, cur_hr_units, cur_min_tens, cur_min_units;
  logic       sec_tick, load;
  logic [3:0] set_hr_tens, set_hr_units, set_min_tens, set_min_units;
  logic       edit_hr, edit_min;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .cur_hr_tens   (cur_hr_tens),
    .cur_hr_units  (cur_hr_units),
    .cur_min_tens  (cur_min_tens),
    .cur_min_units (cur_min_units),
    .sec_tick      (sec_tick),
    .load          (load),
    .set_hr_tens   (set_hr_tens),
    .set_hr_units  (set_hr_units),
    .set_min_tens  (set_min_tens),
    .set_min_units (set_min_units),
    .edit_hr       (edit_hr),
    .edit_min      (edit_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] set_val();
    return {set_hr_tens, set_hr_units, set_min_tens, set_min_units};
  endfunction

  task automatic set_cur(input logic [15:0] t);
    {cur_hr_tens, cur_hr_units, cur_min_tens, cur_min_units} = t;
  endtask

  // Raise a button and wait until the resulting action is visible (edge k+3)
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (4) @(negedge clk);
  endtask

  task automatic release_all();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tap_mode();
    press(1'b1, 1'b0);
    release_all();
  endtask

  task automatic tap_inc();
    press(1'b0, 1'b1);
    release_all();
  endtask

  logic [7:0] hr_exp [12];
  logic       seen_load;

  initial begin
    hr_exp = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
               8'h19, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00};
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    set_cur(16'h0000);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_tick", 32'(sec_tick), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_edit", 32'({edit_hr, edit_min}), 32'd0);
    chk("rst_set", 32'(set_val()), 32'h0000);

    // Prescaler period: ticks in cycles 9, 19, 29 after release
    reset = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("period_tick_c%0d", c), 32'(sec_tick), 32'((c % 10) == 9));
      chk($sformatf("period_load_c%0d", c), 32'(load), 32'd0);
    end

    // inc in RUN is ignored
    set_cur(16'h1234);
    tap_inc();
    chk("run_inc_edit", 32'({edit_hr, edit_min}), 32'd0);
    chk("run_inc_set", 32'(set_val()), 32'h0000);

    // Enter SET_HR capturing 12:34
    press(1'b1, 1'b0);
    chk("enter_edit", 32'({edit_hr, edit_min}), 32'b10);
    chk("enter_set", 32'(set_val()), 32'h1234);
    release_all();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("sethr_tick_off", 32'(sec_tick), 32'd0);
    end

    // 12 increments: 12 -> 23 -> 00
    for (int i = 0; i < 12; i++) begin
      tap_inc();
      chk($sformatf("hr_inc_%0d", i + 1), 32'(set_val()), 32'({hr_exp[i], 8'h34}));
    end

    // To SET_MIN and commit 00:34
    tap_mode();
    chk("to_setmin", 32'({edit_hr, edit_min}), 32'b01);
    press(1'b1, 1'b0);
    chk("commit1_load", 32'(load), 32'd1);
    chk("commit1_set", 32'(set_val()), 32'h0034);
    chk("commit1_edit", 32'({edit_hr, edit_min}), 32'b00);
    release_all();
    chk("commit1_load_gone", 32'(load), 32'd0);

    // Minute wrap and commit 09:00, then tick 10 cycles after load
    set_cur(16'h0959);
    tap_mode();
    chk("cap_0959", 32'(set_val()), 32'h0959);
    tap_mode();
    chk("setmin_0959", 32'({edit_hr, edit_min}), 32'b01);
    tap_inc();
    chk("min_wrap", 32'(set_val()), 32'h0900);
    press(1'b1, 1'b0);
    chk("commit2_load", 32'(load), 32'd1);
    chk("commit2_tick", 32'(sec_tick), 32'd0);
    chk("commit2_set", 32'(set_val()), 32'h0900);
    chk("commit2_edit", 32'({edit_hr, edit_min}), 32'b00);
    btn_mode = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("post_load_tick_c%0d", c), 32'(sec_tick), 32'(c == 10));
      chk($sformatf("post_load_load_c%0d", c), 32'(load), 32'd0);
    end
    repeat (4) @(negedge clk);

    // Sanitise: 27:61 -> 00:00
    set_cur(16'h2761);
    tap_mode();
    chk("san_2761", 32'(set_val()), 32'h0000);
    tap_mode();
    tap_mode();
    // 24:59 -> 00:59 (hours out of range, minutes legal boundary)
    set_cur(16'h2459);
    tap_mode();
    chk("san_2459", 32'(set_val()), 32'h0059);
    tap_mode();
    tap_mode();
    // 23:6x -> 23:00
    set_cur(16'h2360);
    tap_mode();
    chk("san_2360", 32'(set_val()), 32'h2300);
    tap_mode();
    tap_mode();
    // 0A:15 -> 00:15
    set_cur(16'h0A15);
    tap_mode();
    chk("san_0A15", 32'(set_val()), 32'h0015);
    chk("san_0A15_edit", 32'({edit_hr, edit_min}), 32'b10);

    // Simultaneous mode+inc in SET_HR, held for 100 cycles
    press(1'b1, 1'b1);
    chk("simul_state", 32'({edit_hr, edit_min}), 32'b01);
    chk("simul_set", 32'(set_val()), 32'h0015);
    seen_load = 1'b0;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      seen_load = seen_load | load;
    end
    chk("hold_no_load", 32'(seen_load), 32'd0);
    chk("hold_state", 32'({edit_hr, edit_min}), 32'b01);
    chk("hold_set", 32'(set_val()), 32'h0015);
    release_all();

    // Back to RUN, then build SET_MIN with 07:45
    tap_mode();
    set_cur(16'h0745);
    tap_mode();
    tap_mode();
    chk("pre_rst_state", 32'({edit_hr, edit_min}), 32'b01);
    chk("pre_rst_set", 32'(set_val()), 32'h0745);

    // Reset mid-edit takes effect without a clock edge
    reset = 1'b0;
    #1;
    chk("midrst_set", 32'(set_val()), 32'h0000);
    chk("midrst_edit", 32'({edit_hr, edit_min}), 32'b00);
    chk("midrst_load", 32'(load), 32'd0);
    chk("midrst_tick", 32'(sec_tick), 32'd0);
    seen_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_load = seen_load | load;
    end
    chk("midrst_no_load", 32'(seen_load), 32'd0);
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("resume_tick_c%0d", c), 32'(sec_tick), 32'(c == 9));
      chk($sformatf("resume_load_c%0d", c), 32'(load), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller and second-tick scheduler for the `digital_clock` datapath. It divides the system clock into a one-cycle `sec_tick` enable for the BCD time counters. It also runs a button-driven mode FSM so the user can edit hours and minutes. The edited values are committed to the counters with a one-cycle parallel-load strobe. It sits between the board push-buttons (already debounced, still asynchronous) and the clock counter block.

## Interface
- `TICK_DIV`, default 50_000_000: system-clock cycles per `sec_tick`. Must be ≥ 2. Benches use 10.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset. Assertion (0) forces all state immediately. Release is synchronous to `clk`.
- `btn_mode`  in  1  mode button, level, asynchronous to `clk`.
- `btn_inc`  in  1  increment button, level, asynchronous to `clk`.
- `cur_hr_tens`, `cur_hr_units`, `cur_min_tens`, `cur_min_units`  in  4 each  live BCD time from the counters.
- `sec_tick`  out  1  one-cycle advance enable for the counters.
- `load`  out  1  one-cycle parallel-load strobe. On `load`, the counters take the `set_*` values and clear seconds to 00.
- `set_hr_tens`, `set_hr_units`, `set_min_tens`, `set_min_units`  out  4 each  shadow BCD time; valid whenever `load`=1.
- `edit_hr`, `edit_min`  out  1 each  high in SET_HR / SET_MIN respectively (display blink select).

## Operation
- **Button input path:** each button passes through a 2-flop synchronizer, then a rising-edge detector (third flop). One press equals one action; holding a button does not repeat.
- **FSM states:** RUN, SET_HR, SET_MIN.
- **RUN:**
  - prescaler active.
  - mode press → SET_HR; on the same edge, capture `cur_hr_*`/`cur_min_*` into shadow.
  - inc press ignored.
- **SET_HR:**
  - inc press: shadow hours +1 in BCD (x9→(x+1)0, 23→00).
  - mode press → SET_MIN.
- **SET_MIN:**
  - inc press: shadow minutes +1 in BCD (x9→(x+1)0, 59→00).
  - mode press → RUN and assert `load` for exactly one cycle.
- **Capture sanitising:** if any captured digit is >9, or the hours value is >23, or the minutes value is >59, that field (hours or minutes) is shadowed as 00.
- **Prescaler:**
  - counter 0..TICK_DIV-1; `sec_tick`=1 in the cycle the count equals TICK_DIV-1, then the counter wraps to 0.
  - outside RUN: counter held at 0 and `sec_tick`=0.
  - counter cleared in the cycle `load` is asserted.
- **Simultaneous edges:** mode and inc edges in the same cycle → mode wins, inc is dropped.
- **Reset mid-edit:** returns to RUN with no `load` and shadow cleared; the counters are not written.

## Timing
- **Reset values:** state RUN; shadow 00:00 (all `set_*`=0); `sec_tick`=0; `load`=0; `edit_hr`=`edit_min`=0; prescaler 0; synchronizer flops 0.
- **Button latency:** with a button first sampled high at clk edge k, the resulting state, shadow or `load` change is registered at edge k+3.
- **Outputs:** all registered; no combinational path from any input to any output.
- **First tick after reset release:** `sec_tick` is high in cycle TICK_DIV-1 counted from the first post-reset edge. Thereafter the period is exactly TICK_DIV cycles.
- **After load:** the first `sec_tick` follows `load` by exactly TICK_DIV cycles.
- **load vs. sec_tick:** never high in the same cycle.
- **edit_hr / edit_min:** change on the same edge as the state.

## Structure
- **Package `clock_pkg`:**
  - state enum `set_state_t` {RUN, SET_HR, SET_MIN}.
  - constants `HR_MAX_TENS`=2, `HR_MAX_UNITS`=3, `MIN_MAX_TENS`=5, `BCD_MAX`=9.
- **Sub-module `tick_gen`:** parameterised on TICK_DIV, with ports `clk`, `reset`, `en`, `clr`, `tick`. Width is $clog2(TICK_DIV).
- **In the top level:** synchronizers, edge detect, FSM and BCD increment logic.

## Test plan
- **Prescaler period:** TICK_DIV=10, release reset, no buttons → `sec_tick` pulses in cycles 9, 19, 29; `load`=0 throughout.
- **Enter edit and wrap hours:** `cur`=12:34; press mode → `edit_hr`=1, shadow 12:34, `sec_tick` stops. Then 12 inc presses → shadow hours 00 (12→…→23→00).
- **Minute edit and commit:** from SET_HR with shadow 09:59, press mode, then inc once → shadow 09:00. Press mode → single-cycle `load` with `set_*`=0,9,0,0; state RUN; the next `sec_tick` comes exactly 10 cycles later.
- **Sanitise:** `cur`=27:61 on entering SET_HR → shadow 00:00. `cur`=0A:15 → shadow 00:15.
- **Simultaneous edges:** mode and inc rise on the same edge in SET_HR → state SET_MIN and shadow hours unchanged. A held button spanning 100 cycles produces one action.
- **Reset mid-edit:** assert `reset`=0 in SET_MIN with shadow 07:45 → all outputs take their reset values immediately, no `load` pulse. After release, `sec_tick` resumes at cycle 9.
